// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types and constants for the cpu_bus responder.
//   state_t  - transaction FSM states (IDLE, REQ, HOLD, DRAIN)
//   access_t - decoded Z80 cycle type (NONE, MEM, IO, INTA)
//   DEFAULT_VECTOR - byte returned on interrupt acknowledge
//   decode() - classifies the current strobe combination
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_MEM,
    ACC_IO,
    ACC_INTA
  } access_t;

  localparam logic [7:0] DEFAULT_VECTOR = 8'hFF;

  // All strobes are active low. Refresh cycles (mreq=0, rfsh=0) fall
  // through to ACC_NONE because the memory term requires rfsh=1.
  function automatic access_t decode(input logic mreq, input logic iorq,
                                     input logic rfsh, input logic m1,
                                     input logic rd, input logic wr);
    access_t kind;
    kind = ACC_NONE;
    if (!iorq && !m1)
      kind = ACC_INTA;
    else if (!mreq && rfsh && (!rd || !wr))
      kind = ACC_MEM;
    else if (!iorq && m1 && (!rd || !wr))
      kind = ACC_IO;
    return kind;
  endfunction

endpackage

// File: rtl/cpu_bus_irq_timer.sv
// irq_timer: timed interrupt line for the CPU INT_n input.
//   clock, reset (async, active low)
//   cep  - CPU clock enable; each high clock is one tick of the timer
//   irq  - one-clock request pulse, (re)loads the counter with INT_LEN
//   inta - interrupt acknowledge in progress, cancels the pending request
//   mi   - registered INT_n, low while the counter is non-zero
module irq_timer #(
  parameter int INT_LEN = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic cep,
  input  logic irq,
  input  logic inta,
  output logic mi
);

  localparam int CW = $clog2(INT_LEN + 1);

  logic [CW-1:0] count;

  // irq has priority over inta so a new request arriving during the
  // acknowledge of the previous one is not lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      mi    <= 1'b1;
    end else if (irq) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // flop samples the pre-edge values regardless of statement order.
      count <= CW'(INT_LEN);
      mi    <= 1'b0;
    end else if (inta) begin
      count <= '0;
      mi    <= 1'b1;
    end else if (cep && count != '0) begin
      count <= count - CW'(1);
      mi    <= (count == CW'(1));
    end
  end

endmodule

// File: rtl/cpu_bus.sv
// cpu_bus: Z80 bus responder. Decodes memory, I/O and interrupt-acknowledge
// cycles, stretches memory/IO accesses with wait_n and forwards each one as a
// single req/ack transaction on the backend channel, and times the mi line.
//   clock, reset (async, active low)
//   cep, mreq, iorq, rfsh, m1, rd, wr, a, q - CPU side inputs
//   d, wait_n, mi                           - CPU side outputs
//   irq                                     - interrupt request pulse
//   bus_req, bus_io, bus_we, bus_a, bus_d   - backend request (latched)
//   bus_q, bus_ack                          - backend response
module cpu_bus
  import cpu_bus_pkg::*;
#(
  parameter int         INT_LEN = 32,
  parameter logic [7:0] VECTOR  = DEFAULT_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cep,
  input  logic        mreq,
  input  logic        iorq,
  input  logic        rfsh,
  input  logic        m1,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] a,
  input  logic [7:0]  q,
  output logic [7:0]  d,
  output logic        wait_n,
  output logic        mi,
  input  logic        irq,
  output logic        bus_req,
  output logic        bus_io,
  output logic        bus_we,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d,
  input  logic [7:0]  bus_q,
  input  logic        bus_ack
);

  access_t    access;
  state_t     state;
  logic       is_access;
  logic       inta;
  logic       same_access;
  logic       aborted;
  logic [7:0] d_reg;

  assign access    = decode(mreq, iorq, rfsh, m1, rd, wr);
  assign is_access = (access == ACC_MEM) || (access == ACC_IO);
  assign inta      = (access == ACC_INTA);

  // In HOLD the strobes may change to a new access without an idle gap in
  // between; any difference from the latched transaction marks a new one.
  assign same_access = ((access == ACC_IO) == bus_io) && (!wr == bus_we) &&
                       (a == bus_a);

  // Combinational so the CPU sees WAIT_n in T2 of the cycle it decodes.
  assign wait_n = !(is_access && state != ST_HOLD);
  assign d      = inta ? VECTOR : d_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      bus_req <= 1'b0;
      bus_io  <= 1'b0;
      bus_we  <= 1'b0;
      bus_a   <= '0;
      bus_d   <= '0;
      d_reg   <= 8'hFF;
      aborted <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_access) begin
            bus_a   <= a;
            bus_d   <= q;
            bus_io  <= (access == ACC_IO);
            bus_we  <= !wr;
            bus_req <= 1'b1;
            aborted <= 1'b0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Once the CPU walks away the backend transaction still has to
          // finish; remember that so we skip HOLD when it does.
          if (!is_access)
            aborted <= 1'b1;
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we)
              d_reg <= bus_q;
            state <= (aborted || !is_access) ? ST_IDLE : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!is_access)
            state <= ST_IDLE;
          else if (!same_access)
            state <= ST_DRAIN;
        end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  irq_timer #(
    .INT_LEN(INT_LEN)
  ) u_irq_timer (
    .clock(clock),
    .reset(reset),
    .cep  (cep),
    .irq  (irq),
    .inta (inta),
    .mi   (mi)
  );

endmodule

// File: tb/tb_cpu_bus.sv
// tb_cpu_bus: self-checking bench for cpu_bus. Directed scenarios plus a
// randomized run of backend transactions checked against expected values
// derived from the access rules (latched fields, stretch length, read data).
module tb_cpu_bus;

  localparam int TB_INT_LEN = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cep = 1'b0;
  logic        mreq = 1'b1, iorq = 1'b1, rfsh = 1'b1, m1 = 1'b1;
  logic        rd = 1'b1, wr = 1'b1;
  logic [15:0] a = '0;
  logic [7:0]  q = '0;
  logic [7:0]  d;
  logic        wait_n, mi;
  logic        irq = 1'b0;
  logic        bus_req, bus_io, bus_we;
  logic [15:0] bus_a;
  logic [7:0]  bus_d;
  logic [7:0]  bus_q = '0;
  logic        bus_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_d;   // last byte the CPU should have read back

  cpu_bus #(.INT_LEN(TB_INT_LEN), .VECTOR(8'hFF)) dut (
    .clock(clock), .reset(reset), .cep(cep),
    .mreq(mreq), .iorq(iorq), .rfsh(rfsh), .m1(m1), .rd(rd), .wr(wr),
    .a(a), .q(q), .d(d), .wait_n(wait_n), .mi(mi), .irq(irq),
    .bus_req(bus_req), .bus_io(bus_io), .bus_we(bus_we),
    .bus_a(bus_a), .bus_d(bus_d), .bus_q(bus_q), .bus_ack(bus_ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic release_strobes();
    mreq = 1'b1; iorq = 1'b1; m1 = 1'b1; rd = 1'b1; wr = 1'b1;
  endtask

  // One CPU access answered by the backend n clocks after bus_req rises.
  // Expected: wait_n low n+1 clocks, bus_req high n clocks, fields latched.
  task automatic do_access(input bit io, input bit we, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rdata,
                           input int n);
    int wait_cnt = 0;
    int req_cnt = 0;
    a = addr; q = wdata;
    if (io) begin iorq = 1'b0; m1 = 1'b1; end
    else mreq = 1'b0;
    if (we) wr = 1'b0; else rd = 1'b0;
    #1 check("wait_low_on_decode", wait_n, 1'b0);
    for (int c = 0; c <= n; c++) begin
      bus_ack = (c == n);
      bus_q   = (c == n) ? rdata : 8'h00;
      @(negedge clock);
      if (!wait_n) wait_cnt++;
      if (bus_req) req_cnt++;
      if (c == 1) begin
        check("bus_io", bus_io, io);
        check("bus_we", bus_we, we);
        check("bus_a", bus_a, addr);
        if (we) check("bus_d", bus_d, wdata);
      end
      step();
    end
    bus_ack = 1'b0;
    if (!we) exp_d = rdata;
    check("wait_released", wait_n, 1'b1);
    check("req_cleared", bus_req, 1'b0);
    check("read_data", d, exp_d);
    check("wait_clocks", wait_cnt, n + 1);
    check("req_clocks", req_cnt, n);
    release_strobes();
    step();
    step();
  endtask

  initial begin
    int low_cnt;
    int req_cnt;
    bit got_high;

    // ---- reset state
    #12;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_d", d, 8'hFF);
    check("rst_mi", mi, 1'b1);
    check("rst_wait_n", wait_n, 1'b1);
    check("rst_bus_a", bus_a, 16'h0000);
    check("rst_bus_d", bus_d, 8'h00);
    check("rst_bus_io_we", {bus_io, bus_we}, 2'b00);
    exp_d = 8'hFF;
    @(negedge clock) reset = 1'b1;
    step();

    // ---- memory read, ack 3 clocks after bus_req
    do_access(1'b0, 1'b0, 16'h4000, 8'h00, 8'h5A, 3);
    // ---- I/O write, ack in 1 clock
    do_access(1'b1, 1'b1, 16'h0080, 8'h21, 8'h00, 1);

    // ---- refresh cycle is ignored
    mreq = 1'b0; rfsh = 1'b0; rd = 1'b0;
    #1 check("rfsh_wait_n", wait_n, 1'b1);
    req_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus_req) req_cnt++;
      step();
    end
    check("rfsh_no_req", req_cnt, 0);
    rfsh = 1'b1;
    release_strobes();
    step();

    // ---- irq timer: cep every 2nd clock, no INTA
    irq = 1'b1; cep = 1'b1;
    step();
    irq = 1'b0;
    low_cnt = 0;
    got_high = 1'b0;
    for (int i = 1; i < 40 && !got_high; i++) begin
      cep = (i % 2 == 0);
      @(negedge clock);
      if (mi) got_high = 1'b1;
      else low_cnt++;
      step();
    end
    cep = 1'b0;
    check("mi_returned_high", got_high, 1'b1);
    check("mi_low_clocks", low_cnt, 2 * TB_INT_LEN);

    // ---- irq timer with INTA after the 2nd tick
    irq = 1'b1; cep = 1'b1;
    step();
    irq = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cep = (i % 2 == 0);
      step();
    end
    cep = 1'b0;
    iorq = 1'b0; m1 = 1'b0;
    #1;
    check("inta_mi_still_low", mi, 1'b0);
    check("inta_vector", d, 8'hFF);
    check("inta_wait_n", wait_n, 1'b1);
    @(negedge clock);
    check("inta_no_req", bus_req, 1'b0);
    step();
    check("inta_mi_released", mi, 1'b1);
    release_strobes();
    step();

    // ---- irq in the same clock as INTA: irq wins
    iorq = 1'b0; m1 = 1'b0; irq = 1'b1;
    step();
    irq = 1'b0;
    release_strobes();
    check("irq_wins_mi", mi, 1'b0);
    cep = 1'b1;
    for (int i = 0; i < TB_INT_LEN - 1; i++) step();
    check("reload_mi_low", mi, 1'b0);
    step();
    check("reload_mi_high", mi, 1'b1);
    cep = 1'b0;

    // ---- abort: strobes withdrawn in REQ, ack 5 clocks later
    a = 16'h2000; mreq = 1'b0; rd = 1'b0;
    step();
    release_strobes();
    req_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      if (bus_req) req_cnt++;
      step();
    end
    check("abort_req_held", req_cnt, 4);
    bus_ack = 1'b1; bus_q = 8'h33;
    step();
    bus_ack = 1'b0;
    check("abort_req_cleared", bus_req, 1'b0);
    // follows immediately: must be accepted from IDLE
    do_access(1'b0, 1'b0, 16'h2001, 8'h00, 8'hC3, 2);

    // ---- randomized transactions
    for (int t = 0; t < 16; t++) begin
      bit io, we;
      logic [15:0] addr;
      logic [7:0] wd, rdv;
      int n;
      io   = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = 16'($urandom);
      wd   = 8'($urandom);
      rdv  = 8'($urandom);
      n    = $urandom_range(1, 4);
      do_access(io, we, addr, wd, rdv, n);
    end

    // ---- reset mid-transaction with mi low
    irq = 1'b1;
    step();
    irq = 1'b0;
    a = 16'h1234; mreq = 1'b0; rd = 1'b0;
    step();
    check("pre_rst_req", bus_req, 1'b1);
    check("pre_rst_mi", mi, 1'b0);
    release_strobes();
    reset = 1'b0;
    #1;
    check("mid_rst_req", bus_req, 1'b0);
    check("mid_rst_mi", mi, 1'b1);
    check("mid_rst_d", d, 8'hFF);
    check("mid_rst_bus_a", bus_a, 16'h0000);
    step();
    reset = 1'b1;
    exp_d = 8'hFF;
    bus_ack = 1'b1; bus_q = 8'h77;
    step();
    bus_ack = 1'b0;
    check("stale_ack_req", bus_req, 1'b0);
    check("stale_ack_d", d, 8'hFF);
    check("stale_ack_wait", wait_n, 1'b1);
    do_access(1'b0, 1'b0, 16'h8001, 8'h00, 8'h9E, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus.md
# cpu_bus

Bus responder on the far side of the `cpu` wrapper.
- Watches the Z80 strobes and decodes memory, I/O and interrupt-acknowledge cycles.
- Stretches each memory or I/O access with `wait_n` and turns it into one request/acknowledge transaction on a shared backend channel (RAM, ROM, video, ports).
- Generates the timed `mi` interrupt line that feeds the CPU `INT_n`.

## Interface
Parameters:
- INT_LEN, 32, `mi` low duration in `cep` ticks (≥1)
- VECTOR, 8'hFF, byte driven on `d` during interrupt acknowledge

Ports:
- clock  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-low reset
- cep  in  1  CPU positive clock enable (times `mi`)
- mreq  in  1  CPU memory request, active low
- iorq  in  1  CPU I/O request, active low
- rfsh  in  1  CPU refresh, active low
- m1  in  1  CPU M1, active low
- rd  in  1  CPU read strobe, active low
- wr  in  1  CPU write strobe, active low
- a  in  16  CPU address
- q  in  8  CPU write data
- d  out  8  read data to CPU
- wait_n  out  1  to CPU WAIT_n
- mi  out  1  to CPU INT_n
- irq  in  1  one-clock interrupt request pulse (e.g. frame)
- bus_req  out  1  backend request, level
- bus_io  out  1  1 = I/O space, 0 = memory
- bus_we  out  1  1 = write
- bus_a  out  16  latched address
- bus_d  out  8  latched write data
- bus_q  in  8  backend read data, valid with bus_ack
- bus_ack  in  1  one-clock completion pulse

## Operation
Access decode is combinational from the strobes.
- **Memory access:** `mreq`=0 & `rfsh`=1 & (`rd`=0 | `wr`=0).
- **I/O access:** `iorq`=0 & `m1`=1 & (`rd`=0 | `wr`=0).
- **Interrupt ack (INTA):** `iorq`=0 & `m1`=0.
- **Refresh** (`mreq`=0 & `rfsh`=0) is ignored.

FSM states are IDLE, REQ, HOLD, DRAIN.
- **IDLE:** on a valid memory or I/O access, latch `a`, `q`, space and direction into `bus_*`, then go to REQ.
- **REQ:** `bus_req`=1.
  - On `bus_ack`: latch `bus_q` into `d` when reading, clear `bus_req`, go to HOLD.
  - If the strobes vanish before the ack (abort), stay in REQ until the ack, then go to IDLE. A backend transaction is never dropped.
- **HOLD:** wait for the access to deassert, then go to IDLE.
- **DRAIN:** entered from HOLD if a new access is decoded in the same cycle the old one ends (back-to-back). Go to IDLE after one clock, so the new access is accepted from IDLE.

`wait_n` = 0 whenever a memory or I/O access is decoded and state ≠ HOLD. It is combinational so the CPU samples it in T2 of the same cycle.

INTA:
- `d` = VECTOR combinationally, with no backend request and `wait_n`=1.
- INTA also releases `mi`.

Interrupt timer:
- An `irq` pulse loads the counter with INT_LEN and drives `mi`=0.
- The counter decrements on each clock with `cep`=1; `mi` returns to 1 when it reaches 0.
- INTA detected clears the counter, so `mi`=1 on the next clock.
- `irq` arriving while pending reloads the counter.
- `irq` in the same cycle as INTA: `irq` wins, so the counter reloads and `mi` stays 0.

## Timing
Reset values: state IDLE, `bus_req`=0, `bus_io`=0, `bus_we`=0, `bus_a`=0, `bus_d`=0, `d`=8'hFF, `mi`=1, counter 0. `wait_n` then follows the strobes.

Read access, with the access decoded at edge k:
- `bus_req` = 1 after edge k.
- `bus_ack` sampled at edge k+n (n ≥ 1): `d` valid, `bus_req`=0, `wait_n`=1 after that edge.
- Minimum stretch is 2 clocks, when `bus_ack` is combinational.

Writes follow the same timing; `bus_d` captures `q` at edge k, where `wr`=0 already holds.

`mi` low time is exactly INT_LEN `cep` ticks, counted from the clock after `irq`.

Reset asserted mid-transaction: all outputs return to reset values immediately. Any outstanding `bus_ack` after release is ignored in IDLE.

## Structure
Shared package/include `cpu_bus_pkg` holds:
- state encoding (IDLE, REQ, HOLD, DRAIN);
- access-type constants (NONE, MEM, IO, INTA);
- default VECTOR.

Sub-module `irq_timer`: counter and `mi` generation. Inputs `clock`, `reset`, `cep`, `irq`, `inta`; output `mi`; parameter INT_LEN.

## Test plan
- Memory read at a=16'h4000, backend acks 3 clocks after `bus_req` with bus_q=8'h5A → `wait_n` low 4 clocks; `d`=8'h5A; `bus_req` high exactly 3 clocks; bus_io=0, bus_we=0.
- I/O write to a=16'h0080, q=8'h21, ack in 1 clock → one transaction: bus_io=1, bus_we=1, bus_a=16'h0080, bus_d=8'h21; `wait_n` released after ack.
- Refresh cycle (`mreq`=0, `rfsh`=0) → no `bus_req`, `wait_n`=1.
- `irq` pulse, INT_LEN=4, `cep` every 2nd clock, no INTA → `mi` low exactly 8 clocks. Repeat with INTA at tick 2 → `mi` high the clock after INTA, `d`=8'hFF during INTA.
- Strobes withdrawn while in REQ, ack 5 clocks later → `bus_req` held until ack, then IDLE; a following read completes normally.
- `reset` asserted while `bus_req`=1 and `mi`=0 → immediately `bus_req`=0, `mi`=1, `d`=8'hFF; a stale ack after release causes no state change.
